// File: rtl/sensor_conditioner.sv
// Synchronizes and debounces seven asynchronous sensor/button inputs, and derives
// change/press strobes plus a sticky flag for implausible water-level combinations.
module sensor_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_low_water_level,
    input  logic raw_mid_water_level,
    input  logic raw_high_water_level,
    input  logic raw_earth_humidity,
    input  logic raw_air_humidity,
    input  logic raw_low_temperature,
    input  logic raw_selector,
    input  logic clear_error,
    output logic low_water_level,
    output logic mid_water_level,
    output logic high_water_level,
    output logic earth_humidity,
    output logic air_humidity,
    output logic low_temperature,
    output logic selector_pulse,
    output logic sensors_changed,
    output logic water_conflict,
    output logic water_error_latched
);

    localparam int unsigned NCH     = 7;
    localparam int unsigned NSENS   = 6;
    localparam int unsigned CW      = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned CH_LOW  = 0;
    localparam int unsigned CH_MID  = 1;
    localparam int unsigned CH_HIGH = 2;
    localparam int unsigned CH_SEL  = 6;

    logic [NCH-1:0] raw_vec;
    logic [NCH-1:0] sync1_q, sync2_q;
    logic [NCH-1:0] stable_q, stable_d;
    logic [CW-1:0]  cnt_q [NCH];
    logic [CW-1:0]  cnt_d [NCH];
    logic           sel_pulse_q, sel_pulse_d;
    logic           changed_q, changed_d;
    logic           conflict_q, conflict_d;
    logic           err_q, err_d;

    assign raw_vec = {raw_selector, raw_low_temperature, raw_air_humidity, raw_earth_humidity,
                      raw_high_water_level, raw_mid_water_level, raw_low_water_level};

    // Per-channel debounce: a differing sample must persist DEBOUNCE_CYCLES cycles to be accepted.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < int'(NCH); i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    // Strobes fire alongside the debounced update; the flag path lags the debounced levels.
    always_comb begin
        sel_pulse_d = stable_d[CH_SEL] & ~stable_q[CH_SEL];
        changed_d   = |(stable_d[NSENS-1:0] ^ stable_q[NSENS-1:0]);
        conflict_d  = (stable_q[CH_HIGH] & ~stable_q[CH_MID]) |
                      (stable_q[CH_MID]  & ~stable_q[CH_LOW]);
        err_d       = conflict_q | (err_q & ~clear_error);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            stable_q    <= '0;
            cnt_q       <= '{default: '0};
            sel_pulse_q <= 1'b0;
            changed_q   <= 1'b0;
            conflict_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sync1_q     <= raw_vec;
            sync2_q     <= sync1_q;
            stable_q    <= stable_d;
            cnt_q       <= cnt_d;
            sel_pulse_q <= sel_pulse_d;
            changed_q   <= changed_d;
            conflict_q  <= conflict_d;
            err_q       <= err_d;
        end
    end

    assign low_water_level     = stable_q[CH_LOW];
    assign mid_water_level     = stable_q[CH_MID];
    assign high_water_level    = stable_q[CH_HIGH];
    assign earth_humidity      = stable_q[3];
    assign air_humidity        = stable_q[4];
    assign low_temperature     = stable_q[5];
    assign selector_pulse      = sel_pulse_q;
    assign sensors_changed     = changed_q;
    assign water_conflict      = conflict_q;
    assign water_error_latched = err_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed self-checking bench for sensor_conditioner at DEBOUNCE_CYCLES=4.
module tb_sensor_conditioner;

    logic clock = 1'b0;
    logic reset;
    logic raw_low_water_level, raw_mid_water_level, raw_high_water_level;
    logic raw_earth_humidity, raw_air_humidity, raw_low_temperature;
    logic raw_selector, clear_error;
    logic low_water_level, mid_water_level, high_water_level;
    logic earth_humidity, air_humidity, low_temperature;
    logic selector_pulse, sensors_changed, water_conflict, water_error_latched;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    sensor_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
        .clock               (clock),
        .reset               (reset),
        .raw_low_water_level (raw_low_water_level),
        .raw_mid_water_level (raw_mid_water_level),
        .raw_high_water_level(raw_high_water_level),
        .raw_earth_humidity  (raw_earth_humidity),
        .raw_air_humidity    (raw_air_humidity),
        .raw_low_temperature (raw_low_temperature),
        .raw_selector        (raw_selector),
        .clear_error         (clear_error),
        .low_water_level     (low_water_level),
        .mid_water_level     (mid_water_level),
        .high_water_level    (high_water_level),
        .earth_humidity      (earth_humidity),
        .air_humidity        (air_humidity),
        .low_temperature     (low_temperature),
        .selector_pulse      (selector_pulse),
        .sensors_changed     (sensors_changed),
        .water_conflict      (water_conflict),
        .water_error_latched (water_error_latched)
    );

    function automatic logic [9:0] outs();
        return {low_water_level, mid_water_level, high_water_level, earth_humidity,
                air_humidity, low_temperature, selector_pulse, sensors_changed,
                water_conflict, water_error_latched};
    endfunction

    function automatic logic [5:0] sens();
        return {low_water_level, mid_water_level, high_water_level, earth_humidity,
                air_humidity, low_temperature};
    endfunction

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        for (int e = 1; e <= 3; e++) begin
            tick();
            checks++;
            if (outs() !== 10'b0) begin
                errors++;
                $display("FAIL reset_hold e=%0d got=%b exp=%b", e, outs(), 10'b0);
            end
        end
        reset = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            checks++;
            if (outs() !== 10'b0) begin
                errors++;
                $display("FAIL reset_idle e=%0d got=%b exp=%b", e, outs(), 10'b0);
            end
        end
    endtask

    task automatic test_latency();
        raw_earth_humidity = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            checks++;
            if (earth_humidity !== (e >= 6)) begin
                errors++;
                $display("FAIL latency_earth e=%0d got=%b exp=%b", e, earth_humidity, (e >= 6));
            end
            checks++;
            if (sensors_changed !== (e == 6)) begin
                errors++;
                $display("FAIL latency_changed e=%0d got=%b exp=%b", e, sensors_changed, (e == 6));
            end
        end
    endtask

    task automatic test_glitch();
        raw_air_humidity = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (e == 3) raw_air_humidity = 1'b0;
            checks++;
            if ({air_humidity, sensors_changed} !== 2'b00) begin
                errors++;
                $display("FAIL glitch e=%0d got air/chg=%b exp=00", e, {air_humidity, sensors_changed});
            end
        end
    endtask

    task automatic test_selector();
        raw_selector = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            checks++;
            if ({selector_pulse, sensors_changed} !== {(e == 6), 1'b0}) begin
                errors++;
                $display("FAIL sel_press e=%0d got pulse/chg=%b exp=%b", e,
                         {selector_pulse, sensors_changed}, {(e == 6), 1'b0});
            end
        end
        raw_selector = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            checks++;
            if ({selector_pulse, sensors_changed} !== 2'b00) begin
                errors++;
                $display("FAIL sel_release e=%0d got pulse/chg=%b exp=00", e,
                         {selector_pulse, sensors_changed});
            end
        end
    endtask

    task automatic test_water();
        raw_mid_water_level = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            checks++;
            if ({mid_water_level, water_conflict, water_error_latched} !== {(e >= 6), (e >= 7), (e >= 8)}) begin
                errors++;
                $display("FAIL water_set e=%0d got mid/conf/err=%b exp=%b", e,
                         {mid_water_level, water_conflict, water_error_latched},
                         {(e >= 6), (e >= 7), (e >= 8)});
            end
        end
        clear_error = 1'b1;
        tick();
        clear_error = 1'b0;
        checks++;
        if ({water_conflict, water_error_latched} !== 2'b11) begin
            errors++;
            $display("FAIL water_set_wins got conf/err=%b exp=11", {water_conflict, water_error_latched});
        end
        raw_low_water_level = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            checks++;
            if ({low_water_level, water_conflict, water_error_latched} !== {(e >= 6), (e < 7), 1'b1}) begin
                errors++;
                $display("FAIL water_restore e=%0d got low/conf/err=%b exp=%b", e,
                         {low_water_level, water_conflict, water_error_latched},
                         {(e >= 6), (e < 7), 1'b1});
            end
        end
        clear_error = 1'b1;
        tick();
        clear_error = 1'b0;
        checks++;
        if ({water_conflict, water_error_latched} !== 2'b00) begin
            errors++;
            $display("FAIL water_clear got conf/err=%b exp=00", {water_conflict, water_error_latched});
        end
        checks++;
        if (sens() !== 6'b110100) begin
            errors++;
            $display("FAIL clear_isolation got sens=%b exp=110100", sens());
        end
        tick();
        checks++;
        if (water_error_latched !== 1'b0) begin
            errors++;
            $display("FAIL water_clear_hold got err=%b exp=0", water_error_latched);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] old_v;
        logic [5:0] new_v;
        old_v = 6'b110100;
        new_v = 6'b001011;
        {raw_low_water_level, raw_mid_water_level, raw_high_water_level,
         raw_earth_humidity, raw_air_humidity, raw_low_temperature} = new_v;
        for (int e = 1; e <= 8; e++) begin
            tick();
            checks++;
            if (sens() !== ((e >= 6) ? new_v : old_v)) begin
                errors++;
                $display("FAIL simul_sens e=%0d got=%b exp=%b", e, sens(), ((e >= 6) ? new_v : old_v));
            end
            checks++;
            if ({sensors_changed, selector_pulse} !== {(e == 6), 1'b0}) begin
                errors++;
                $display("FAIL simul_strobe e=%0d got chg/pulse=%b exp=%b", e,
                         {sensors_changed, selector_pulse}, {(e == 6), 1'b0});
            end
        end
    endtask

    task automatic test_reset_midcount();
        tick();
        tick();
        raw_low_water_level = 1'b1;
        raw_selector        = 1'b1;
        for (int e = 1; e <= 4; e++) tick();
        #2 reset = 1'b1;
        #1;
        checks++;
        if (outs() !== 10'b0) begin
            errors++;
            $display("FAIL reset_async got=%b exp=%b", outs(), 10'b0);
        end
        for (int e = 1; e <= 3; e++) begin
            tick();
            checks++;
            if (outs() !== 10'b0) begin
                errors++;
                $display("FAIL reset_mid_hold e=%0d got=%b exp=%b", e, outs(), 10'b0);
            end
        end
        reset = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            checks++;
            if (sens() !== ((e >= 6) ? 6'b101011 : 6'b000000)) begin
                errors++;
                $display("FAIL reset_recount e=%0d got=%b exp=%b", e, sens(),
                         ((e >= 6) ? 6'b101011 : 6'b000000));
            end
            checks++;
            if ({selector_pulse, sensors_changed, water_conflict} !== {(e == 6), (e == 6), (e >= 7)}) begin
                errors++;
                $display("FAIL reset_strobes e=%0d got pulse/chg/conf=%b exp=%b", e,
                         {selector_pulse, sensors_changed, water_conflict},
                         {(e == 6), (e == 6), (e >= 7)});
            end
        end
    endtask

    initial begin
        reset                = 1'b1;
        raw_low_water_level  = 1'b0;
        raw_mid_water_level  = 1'b0;
        raw_high_water_level = 1'b0;
        raw_earth_humidity   = 1'b0;
        raw_air_humidity     = 1'b0;
        raw_low_temperature  = 1'b0;
        raw_selector         = 1'b0;
        clear_error          = 1'b0;
        test_reset();
        test_latency();
        test_glitch();
        test_selector();
        test_water();
        test_back_to_back();
        test_reset_midcount();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sensor_conditioner.md
SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES: default 4; consecutive stable synchronized samples required to accept a new level; legal range 2..255.
REQ-002 The block SHALL have port clock: input, 1 bit, system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset: input, 1 bit, asynchronous, active-high.
REQ-004 The block SHALL have inputs raw_low_water_level, raw_mid_water_level and raw_high_water_level, each 1 bit, asynchronous float-switch levels.
REQ-005 The block SHALL have inputs raw_earth_humidity, raw_air_humidity and raw_low_temperature, each 1 bit, asynchronous sensor levels.
REQ-006 The block SHALL have input raw_selector, 1 bit, asynchronous mode pushbutton.
REQ-007 The block SHALL have input clear_error, 1 bit, synchronous request to clear the sticky water error.
REQ-008 The block SHALL have outputs low_water_level, mid_water_level, high_water_level, earth_humidity, air_humidity and low_temperature, each 1 bit, debounced levels.
REQ-009 The block SHALL have output selector_pulse, 1 bit, one-cycle strobe on a debounced press.
REQ-010 The block SHALL have output sensors_changed, 1 bit, one-cycle strobe when any debounced sensor output changes.
REQ-011 The block SHALL have output water_conflict, 1 bit, registered implausible water-level combination.
REQ-012 The block SHALL have output water_error_latched, 1 bit, sticky copy of water_conflict.

Function
REQ-013 The block SHALL pass each of the 7 raw inputs through its own 2-flop synchronizer before any other logic uses it.
REQ-014 The block SHALL give each channel a stable register and a counter sized ceil(log2(DEBOUNCE_CYCLES)) bits.
REQ-015 When a channel's synchronized value equals its stable value, its counter SHALL clear to 0.
REQ-016 When the values differ and the counter is below DEBOUNCE_CYCLES-1, the counter SHALL increment.
REQ-017 When the values differ and the counter equals DEBOUNCE_CYCLES-1, the stable register SHALL load the synchronized value and the counter SHALL clear.
REQ-018 Latency SHALL be fixed: a raw level held from before edge k appears on the output after edge k+DEBOUNCE_CYCLES+1.
REQ-019 A synchronized glitch shorter than DEBOUNCE_CYCLES cycles SHALL leave the output unchanged and restart that channel's count.
REQ-020 Channels SHALL be independent; simultaneous changes on several channels SHALL each follow REQ-015 to REQ-018 and never overflow the counter.
REQ-021 selector_pulse SHALL be high for exactly one cycle, in the cycle after the debounced selector goes 0->1; release SHALL produce no pulse.
REQ-022 sensors_changed SHALL be high for exactly one cycle after any of the six debounced sensor outputs changes; selector changes SHALL be excluded; several channels updating on the same edge SHALL give one strobe.
REQ-023 water_conflict SHALL be registered and equal (high & ~mid) | (mid & ~low), computed from the debounced water levels; it lags those outputs by one cycle.
REQ-024 water_error_latched SHALL set on any cycle where water_conflict is 1.
REQ-025 water_error_latched SHALL clear on a cycle where clear_error is 1 and water_conflict is 0; when clear_error and water_conflict are both 1, set SHALL win.
REQ-026 clear_error SHALL have no effect on any other state.

Reset
REQ-027 While reset is high, all synchronizers, stable registers, counters and strobe/edge registers SHALL be 0, asynchronously.
REQ-028 While reset is high, every output SHALL be 0.
REQ-029 Reset asserted mid-count SHALL discard the count; after release, the channel SHALL need a full DEBOUNCE_CYCLES count.
REQ-030 After reset release, debounced inputs that are already high SHALL produce a normal 0->1 update and a sensors_changed strobe; if the debounced selector is high, selector_pulse SHALL fire.

Verification (DEBOUNCE_CYCLES=4)
REQ-031 Drive raw_earth_humidity 0->1 before edge 1 and hold -> earth_humidity rises after edge 6; sensors_changed is high for exactly the cycle after edge 6.
REQ-032 Drive a 3-cycle high glitch on raw_air_humidity -> air_humidity and sensors_changed stay 0 throughout.
REQ-033 Hold raw_selector high for 20 cycles, then low -> exactly one selector_pulse; no pulse on release.
REQ-034 Set raw low=0, mid=1, high=0 -> water_conflict=1 one cycle after mid_water_level rises and water_error_latched sets; restore low=1 and pulse clear_error -> both return to 0; clear_error while the conflict persists -> latch stays 1.
REQ-035 Change all six sensor raws on the same edge -> all six outputs update on the same edge with a single one-cycle sensors_changed.
REQ-036 Assert reset 2 cycles into a count on raw_low_water_level -> all outputs are 0 immediately; after release, low_water_level rises only after a full DEBOUNCE_CYCLES+2 edges.
